uart_rx_fifo: RTL and testbench

Parametrised UART receiver and successor to the single-byte `UartRx`. It supports configurable data width, one or two stop bits, optional parity and a receive FIFO. Each received frame is pushed into the FIFO with per-frame error flags, and the consumer pops entries with `ack_i`. When the FIFO is full, new frames are dropped and a sticky overrun flag is set, so data already queued is never overwritten. The block sits between the pad-level `serial_i` line and the bus-side register interface.

---
 rtl/uart_rx_fifo.sv | 193 +++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable frame format and a receive FIFO carrying per-frame error flags.
// Frames arriving while the FIFO is full are dropped and flagged with a sticky overrun.
module uart_rx_fifo #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 serial_i,
    input  logic [15:0]          clock_divider_i,
    input  logic                 parity_bit_i,
    input  logic                 parity_even_i,
    input  logic                 two_stop_i,
    input  logic                 ack_i,
    input  logic                 clear_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 ready_o,
    output logic [CNT_W-1:0]     count_o,
    output logic                 overrun_o
);

    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned PW  = AW + 1;
    localparam int unsigned EW  = DATA_BITS + 2;
    localparam int unsigned BCW = 4;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

    state_t               state_q, state_n;
    logic                 s1_q, s2_q, rx_q, rx;
    logic [15:0]          timer_q, timer_n, div_q, div_n, div_sel;
    logic [DATA_BITS-1:0] shift_q, shift_n;
    logic [BCW-1:0]       bit_q, bit_n;
    logic                 perr_q, perr_n, ferr_q, ferr_n;
    logic                 expire, push_c;
    logic [EW-1:0]        push_entry;

    assign rx      = s2_q;
    assign expire  = (timer_q == 16'd0);
    assign div_sel = (clock_divider_i < 16'd2) ? 16'd2 : clock_divider_i;

    // Synchroniser, edge-detect history and receiver state
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            rx_q    <= 1'b1;
            state_q <= IDLE;
            timer_q <= 16'd0;
            div_q   <= 16'd2;
            shift_q <= '0;
            bit_q   <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            s1_q    <= serial_i;
            s2_q    <= s1_q;
            rx_q    <= rx;
            state_q <= state_n;
            timer_q <= timer_n;
            div_q   <= div_n;
            shift_q <= shift_n;
            bit_q   <= bit_n;
            perr_q  <= perr_n;
            ferr_q  <= ferr_n;
        end
    end

    // Bit timing and frame decode; every bit is sampled on timer expiry
    always_comb begin
        state_n = state_q;
        timer_n = timer_q;
        div_n   = div_q;
        shift_n = shift_q;
        bit_n   = bit_q;
        perr_n  = perr_q;
        ferr_n  = ferr_q;
        push_c  = 1'b0;
        if (state_q != IDLE && !expire) begin
            timer_n = timer_q - 16'd1;
        end
        unique case (state_q)
            IDLE: begin
                if (rx_q && !rx) begin
                    div_n   = div_sel;
                    timer_n = (div_sel >> 1) - 16'd1;
                    bit_n   = '0;
                    perr_n  = 1'b0;
                    ferr_n  = 1'b0;
                    state_n = START;
                end
            end
            START: begin
                if (expire) begin
                    if (rx) begin
                        state_n = IDLE;
                    end else begin
                        timer_n = div_q - 16'd1;
                        state_n = DATA;
                    end
                end
            end
            DATA: begin
                if (expire) begin
                    shift_n = {rx, shift_q[DATA_BITS-1:1]};
                    bit_n   = bit_q + BCW'(1);
                    timer_n = div_q - 16'd1;
                    if (bit_q == BCW'(DATA_BITS - 1)) begin
                        state_n = parity_bit_i ? PARITY : STOP1;
                    end
                end
            end
            PARITY: begin
                if (expire) begin
                    perr_n  = rx ^ (^shift_q) ^ ~parity_even_i;
                    timer_n = div_q - 16'd1;
                    state_n = STOP1;
                end
            end
            STOP1: begin
                if (expire) begin
                    ferr_n = ferr_q | ~rx;
                    if (two_stop_i) begin
                        timer_n = div_q - 16'd1;
                        state_n = STOP2;
                    end else begin
                        push_c  = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            STOP2: begin
                if (expire) begin
                    ferr_n  = ferr_q | ~rx;
                    push_c  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        push_entry = {ferr_n, perr_n, shift_n};
    end

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [EW-1:0] last_q, head, shown;
    logic          empty, full, pop, wr_en, ovf;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop   = ack_i && !empty;
    assign wr_en = push_c && (!full || pop);
    assign ovf   = push_c && full && !pop;
    assign head  = mem[rd_q[AW-1:0]];

    always_ff @(posedge clock_i) begin
        if (wr_en) begin
            mem[wr_q[AW-1:0]] <= push_entry;
        end
    end

    // Pointers, last popped entry (shown while empty) and sticky overrun
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_q      <= '0;
            rd_q      <= '0;
            last_q    <= '0;
            overrun_o <= 1'b0;
        end else begin
            if (wr_en) wr_q <= wr_q + PW'(1);
            if (pop) begin
                rd_q   <= rd_q + PW'(1);
                last_q <= head;
            end
            if (ovf) begin
                overrun_o <= 1'b1;
            end else if (clear_i) begin
                overrun_o <= 1'b0;
            end
        end
    end

    assign shown        = empty ? last_q : head;
    assign data_o       = shown[DATA_BITS-1:0];
    assign parity_err_o = shown[DATA_BITS];
    assign frame_err_o  = shown[DATA_BITS+1];
    assign ready_o      = !empty;
    assign count_o      = CNT_W'(wr_q - rd_q);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frames are modelled at issue time, a monitor pops and compares.
module tb_uart_rx_fifo;

    localparam int unsigned DEPTH = 4;

    logic        clock_i = 1'b0;
    logic        reset_i, serial_i, parity_bit_i, parity_even_i, two_stop_i, ack_i, clear_i;
    logic [15:0] clock_divider_i;
    logic [7:0]  data_o;
    logic        parity_err_o, frame_err_o, ready_o, overrun_o;
    logic [2:0]  count_o;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   mode = 0;
    int   cyc = 0;
    int   last_start = -1000;
    int   collide_off = 0;
    logic exp_ov = 1'b0;

    uart_rx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .serial_i(serial_i),
        .clock_divider_i(clock_divider_i), .parity_bit_i(parity_bit_i),
        .parity_even_i(parity_even_i), .two_stop_i(two_stop_i), .ack_i(ack_i),
        .clear_i(clear_i), .data_o(data_o), .parity_err_o(parity_err_o),
        .frame_err_o(frame_err_o), .ready_o(ready_o), .count_o(count_o),
        .overrun_o(overrun_o)
    );

    always #5 clock_i = ~clock_i;
    always @(posedge clock_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: decides ack each cycle; every pop of a present entry is scored against the model
    initial begin
        logic a;
        exp_t e;
        ack_i = 1'b0;
        forever begin
            @(negedge clock_i);
            a = 1'b0;
            if (reset_i) begin
                case (mode)
                    1:       a = ($urandom_range(0, 1) == 1);
                    2:       a = 1'b1;
                    3:       a = (cyc == last_start + collide_off);
                    default: a = 1'b0;
                endcase
            end
            if (a && ready_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_entry: got data 0x%0h, no entry required", data_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_data", 32'(data_o), 32'(e.d));
                    chk("pop_parity_err", 32'(parity_err_o), 32'(e.pe));
                    chk("pop_frame_err", 32'(frame_err_o), 32'(e.fe));
                end
            end
            ack_i = a;
        end
    end

    // Drive one frame bit by bit; the expected entry is derived from the frame rules up front
    task automatic send(input logic [7:0] d, input int div, input logic pen, input logic even,
                        input logic bad_par, input logic two, input logic s1low,
                        input logic s2low, input logic collide);
        int   per;
        exp_t e;
        logic pb;
        per  = (div < 2) ? 2 : div;
        pb   = ((($countones(d) % 2) == 1) ^ !even) ^ bad_par;
        e.d  = d;
        e.pe = pen && bad_par;
        e.fe = s1low || (two && s2low);
        if (exp_q.size() < DEPTH || collide) exp_q.push_back(e);
        else exp_ov = 1'b1;
        @(negedge clock_i);
        clock_divider_i = 16'(div);
        parity_bit_i    = pen;
        parity_even_i   = even;
        two_stop_i      = two;
        serial_i        = 1'b0;
        last_start      = cyc;
        repeat (per) @(negedge clock_i);
        for (int i = 0; i < 8; i++) begin
            serial_i = d[i];
            repeat (per) @(negedge clock_i);
        end
        if (pen) begin
            serial_i = pb;
            repeat (per) @(negedge clock_i);
        end
        serial_i = !s1low;
        repeat (per) @(negedge clock_i);
        if (two) begin
            serial_i = !s2low;
            repeat (per) @(negedge clock_i);
        end
        serial_i = 1'b1;
        repeat (per) @(negedge clock_i);
    endtask

    task automatic drain();
        int n;
        n    = 0;
        mode = 2;
        while ((exp_q.size() != 0 || ready_o) && n < 400) begin
            @(negedge clock_i);
            n++;
        end
        mode = 0;
        @(negedge clock_i);
        if (n >= 400) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d entries left, required 0", exp_q.size());
        end
        chk("drained_ready", 32'(ready_o), 32'd0);
        chk("drained_count", 32'(count_o), 32'd0);
    endtask

    initial begin
        reset_i = 1'b0; serial_i = 1'b1; clock_divider_i = 16'd4;
        parity_bit_i = 1'b0; parity_even_i = 1'b1; two_stop_i = 1'b0; clear_i = 1'b0;
        repeat (3) @(negedge clock_i);
        chk("rst_data", 32'(data_o), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_overrun", 32'(overrun_o), 32'd0);
        chk("rst_flags", 32'({parity_err_o, frame_err_o}), 32'd0);
        reset_i = 1'b1;
        repeat (2) @(negedge clock_i);

        // basic 8N1 frame
        send(8'h55, 4, 0, 1, 0, 0, 0, 0, 0);
        chk("basic_ready", 32'(ready_o), 32'd1);
        chk("basic_data", 32'(data_o), 32'h55);
        chk("basic_flags", 32'({parity_err_o, frame_err_o}), 32'd0);
        chk("basic_count", 32'(count_o), 32'd1);
        drain();

        // overrun: fifth frame dropped
        for (int k = 1; k <= 5; k++) send(8'(k), 4, 0, 1, 0, 0, 0, 0, 0);
        chk("ovr_count", 32'(count_o), 32'(exp_q.size()));
        chk("ovr_flag", 32'(overrun_o), 32'(exp_ov));
        drain();
        chk("ovr_sticky", 32'(overrun_o), 32'd1);
        clear_i = 1'b1;
        @(negedge clock_i);
        clear_i = 1'b0;
        exp_ov  = 1'b0;
        chk("ovr_cleared", 32'(overrun_o), 32'd0);

        // even parity good then bad
        send(8'h03, 4, 1, 1, 0, 0, 0, 0, 0);
        send(8'h03, 4, 1, 1, 1, 0, 0, 0, 0);
        chk("par_head_err", 32'(parity_err_o), 32'd0);
        drain();

        // two stop bits, second one low
        send(8'hA5, 4, 0, 1, 0, 1, 0, 1, 0);
        chk("frm_data", 32'(data_o), 32'hA5);
        chk("frm_err", 32'(frame_err_o), 32'd1);
        drain();

        // one-clock glitch is a false start; divider 0 behaves as 2
        @(negedge clock_i);
        clock_divider_i = 16'd8;
        serial_i = 1'b0;
        @(negedge clock_i);
        serial_i = 1'b1;
        repeat (20) @(negedge clock_i);
        chk("glitch_count", 32'(count_o), 32'd0);
        send(8'h3C, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("div0_data", 32'(data_o), 32'h3C);
        drain();

        // push into a full FIFO on the same clock as a pop
        for (int k = 0; k < 4; k++) send(8'h10 + 8'(k), 4, 0, 1, 0, 0, 0, 0, 0);
        chk("coll_full", 32'(count_o), 32'd4);
        collide_off = 2 + 4 / 2 + 9 * 4;
        mode = 3;
        send(8'h99, 4, 0, 1, 0, 0, 0, 0, 1);
        mode = 0;
        chk("coll_count", 32'(count_o), 32'd4);
        chk("coll_overrun", 32'(overrun_o), 32'd0);
        drain();

        // randomized frames with random consumer back-pressure
        mode = 1;
        for (int k = 0; k < 24; k++) begin
            send(8'($urandom), int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 0);
        end
        drain();
        chk("rand_overrun", 32'(overrun_o), 32'(exp_ov));

        // reset in the middle of a frame
        send(8'h42, 4, 0, 1, 0, 0, 0, 0, 0);
        chk("pre_rst_ready", 32'(ready_o), 32'd1);
        @(negedge clock_i);
        serial_i = 1'b0;
        repeat (10) @(negedge clock_i);
        serial_i = 1'b1;
        repeat (5) @(negedge clock_i);
        reset_i = 1'b0;
        @(negedge clock_i);
        chk("mid_rst_data", 32'(data_o), 32'd0);
        chk("mid_rst_ready", 32'(ready_o), 32'd0);
        chk("mid_rst_count", 32'(count_o), 32'd0);
        chk("mid_rst_flags", 32'({parity_err_o, frame_err_o, overrun_o}), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clock_i);
        reset_i = 1'b1;
        repeat (3) @(negedge clock_i);
        send(8'h7E, 4, 0, 1, 0, 0, 0, 0, 0);
        chk("post_rst_data", 32'(data_o), 32'h7E);
        chk("post_rst_count", 32'(count_o), 32'd1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
